spi_slave_reg_ctrl: RTL and testbench
=====================================

Name: spi_slave_reg_ctrl

Overview:
Byte-level transaction controller between the SPI slave byte engine and an 8-bit register bus. It decodes a command byte {RW, ADDR}, then writes or reads consecutive registers with address auto-increment. For reads it prefetches register data and loads it into the slave's transmit buffer before the master clocks the next byte. One instance sits per SPI port, between the SPI slave and the system register file.

Parameters:
ADDR_W, 7, register address width; must be ≤7, command byte bit 7 = RW
RD_TIMEOUT, 16, max Clk cycles from Reg_Rd_En to Reg_Rd_Valid before abort
STATUS_ID, 4'hA, upper nibble of the status byte
DUMMY_BYTE, 8'hEE, byte loaded on read timeout
MAX_ADDR, 7'h7F, highest writable address (used only with optional feature)

Ports:
Clk  in  1  system clock
Rst_n  in  1  reset
Trans_Start  in  1  1-cycle pulse, chip-select asserted
Trans_End  in  1  1-cycle pulse, chip-select released
Rx_Valid  in  1  1-cycle pulse, Rx_Data holds a received byte
Rx_Data  in  8  received byte, MSB-first order
Tx_Load  out  1  1-cycle pulse, loads Tx_Data into the slave transmit buffer
Tx_Data  out  8  byte for the slave to shift out next
Reg_Wr_En  out  1  1-cycle write strobe
Reg_Rd_En  out  1  1-cycle read request
Reg_Addr  out  ADDR_W  register address
Reg_Wr_Data  out  8  write data
Reg_Rd_Data  in  8  read data, valid with Reg_Rd_Valid
Reg_Rd_Valid  in  1  1-cycle read-data strobe
Busy  out  1  high while not IDLE
Err_Rd_Timeout  out  1  sticky read-timeout flag
Byte_Cnt  out  16  data bytes handled in current/last transaction, saturating

Behaviour:
- Reset is asynchronous and active-low on Rst_n; clock is Clk. All outputs reset to 0 and the FSM resets to IDLE.
- States and transitions:
  - IDLE -> CMD on Trans_Start.
  - CMD: on Trans_Start entry, Tx_Load is pulsed with Tx_Data = {STATUS_ID, 3'b000, Err_Rd_Timeout}.
  - CMD, on Rx_Valid: Reg_Addr <= Rx_Data[ADDR_W-1:0] and Byte_Cnt <= 0. If Rx_Data[7]=0, go to WR_DATA; if 1, go to RD_REQ.
  - WR_DATA, on Rx_Valid: next cycle Reg_Wr_En=1 with Reg_Wr_Data=Rx_Data at the current Reg_Addr. The cycle after, Reg_Addr increments and Byte_Cnt increments. Stay in WR_DATA.
  - RD_REQ: Reg_Rd_En is a 1-cycle pulse, then go to RD_WAIT and clear the timeout counter.
  - RD_WAIT, on Reg_Rd_Valid: Tx_Data <= Reg_Rd_Data, Tx_Load pulses next cycle, go to RD_DATA.
  - RD_WAIT timeout: if the counter reaches RD_TIMEOUT-1 without Reg_Rd_Valid, Tx_Data <= DUMMY_BYTE, Tx_Load pulses, Err_Rd_Timeout is set, go to RD_DATA.
  - RD_DATA, on Rx_Valid: the byte clocked in by the master is ignored. Reg_Addr increments, Byte_Cnt increments, go to RD_REQ (prefetch the next register).
- Address wraps modulo 2^ADDR_W (e.g. 7'h7F+1 -> 7'h00).
- Byte_Cnt saturates at 16'hFFFF.
- Trans_End from any non-IDLE state -> IDLE. Any pending read is dropped, and a late Reg_Rd_Valid is ignored.
- Rx_Valid and Trans_End in the same cycle: the byte is processed first (a write still issues in the following cycle), then IDLE.
- Trans_Start while not IDLE: restart in CMD; the status byte is reloaded.
- Rx_Valid in IDLE: ignored.
- Err_Rd_Timeout is cleared only by a write of any value to address 0. The write takes effect, and the flag clears in the same cycle as Reg_Wr_En.
- Busy = (state != IDLE), registered.
- Read turnaround budget: Reg_Rd_Valid latency + 2 cycles must be shorter than one SPI byte period. Integration ensures RD_TIMEOUT+3 Clk cycles is less than 8 SCK periods.

Optional Feature:
SPI_REG_CTRL_ADDR_LIMIT_EN:
- When defined, WR_DATA bytes targeting Reg_Addr > MAX_ADDR raise no Reg_Wr_En. The address still increments, and sticky bit Err_Wr_Range (extra output, reset 0, cleared like Err_Rd_Timeout) is set. The status byte becomes {STATUS_ID, 2'b00, Err_Wr_Range, Err_Rd_Timeout}.
- When undefined, all addresses are writable, the port is absent, and status bit 1 = 0.

Decomposition:
- Shared package spi_reg_pkg holds:
  - the state encoding (IDLE, CMD, WR_DATA, RD_REQ, RD_WAIT, RD_DATA)
  - the CMD_RW_BIT=7 constant
  - the status-byte field positions
  - the default DUMMY_BYTE and STATUS_ID
- One natural sub-module, spi_reg_rd_timer, covers the RD_WAIT timeout counter with start, hit and expire. Everything else stays flat.

Test Plan:
- Write burst: Start, Rx 0x05, 0x11, 0x22, End -> Reg_Wr_En twice: addr 0x05 data 0x11, addr 0x06 data 0x22; Byte_Cnt=2; Busy=0 after End.
- Read burst, latency 2: Start, Rx 0x83 -> Reg_Rd_En addr 0x03, Reg_Rd_Data 0x5A -> Tx_Load Tx_Data 0x5A. Next Rx -> Reg_Rd_En addr 0x04.
- Status on start: reset, Start -> Tx_Load with Tx_Data 0xA0. After a timeout event, the next Start -> 0xA1.
- Read timeout: Rx 0x90, no Reg_Rd_Valid for 16 cycles -> Tx_Data 0xEE, Err_Rd_Timeout=1. Then write 0x00 to addr 0 -> flag clears.
- Wrap and abort: write cmd 0x7F, data 0x01, 0x02 -> writes at 0x7F then 0x00. Read cmd followed by End during RD_WAIT, then late Reg_Rd_Valid -> no Tx_Load, state IDLE.
- Simultaneous: Rx_Valid 0x33 in WR_DATA in the same cycle as Trans_End -> Reg_Wr_En data 0x33 next cycle, then IDLE.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI slave register-bus controller.
// Holds the FSM state encoding, command/status byte layout, default
// constants and a small saturating-increment helper.
package spi_reg_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BYTE_CNT_W = 16;

  // Command byte: bit 7 selects read (1) or write (0), low bits carry the address.
  localparam int unsigned CMD_RW_BIT = 7;

  // Status byte layout: {ID[7:4], 2'b00, wr_range[1], rd_timeout[0]}.
  localparam int unsigned STAT_ID_LSB       = 4;
  localparam int unsigned STAT_ID_W         = 4;
  localparam int unsigned STAT_WR_RANGE_BIT = 1;
  localparam int unsigned STAT_RD_TO_BIT    = 0;

  localparam logic [STAT_ID_W-1:0] DEF_STATUS_ID  = 4'hA;
  localparam logic [BYTE_W-1:0]    DEF_DUMMY_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  // Assemble the status byte shifted out while the command byte is received.
  function automatic logic [BYTE_W-1:0] status_byte(input logic [STAT_ID_W-1:0] id,
                                                    input logic                 wr_range,
                                                    input logic                 rd_to);
    logic [BYTE_W-1:0] s;
    s                              = '0;
    s[STAT_ID_LSB +: STAT_ID_W]    = id;
    s[STAT_WR_RANGE_BIT]           = wr_range;
    s[STAT_RD_TO_BIT]              = rd_to;
    return s;
  endfunction

  // Byte counter increments but sticks at all-ones.
  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_reg_rd_timer.sv
// Read-wait timeout counter.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   start_i    : clears the counter (issued as the read request retires)
//   run_i      : counter advances while waiting for read data
//   hit_i      : read data arrived this cycle, suppresses expiry
//   expire_c   : combinational, last allowed wait cycle passed without data
module spi_reg_rd_timer #(
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic start_i,
  input  logic run_i,
  input  logic hit_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RD_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clear on start, count while waiting, hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)                     cnt_d = '0;
    else if (run_i && cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
  end

  assign expire_c = run_i && !hit_i && !start_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave byte stream to 8-bit register bus transaction controller.
// Decodes a command byte {RW, ADDR}, then writes or reads consecutive
// registers with address auto-increment; read data is prefetched into the
// slave transmit buffer before the master clocks the next byte.
// Optional feature macro: SPI_REG_CTRL_ADDR_LIMIT_EN (write range check,
// adds Err_Wr_Range output and MAX_ADDR parameter).
// Ports:
//   Clk, Rst_n                   : clock, asynchronous active-low reset
//   Trans_Start, Trans_End       : chip-select assert / release pulses
//   Rx_Valid, Rx_Data            : received byte strobe and data
//   Tx_Load, Tx_Data             : transmit buffer load strobe and byte
//   Reg_Wr_En, Reg_Addr,
//   Reg_Wr_Data                  : register write strobe, address, data
//   Reg_Rd_En, Reg_Rd_Data,
//   Reg_Rd_Valid                 : register read request and response
//   Busy                         : transaction in progress
//   Err_Rd_Timeout               : sticky read timeout flag
//   Byte_Cnt                     : data bytes in current/last transaction
module spi_slave_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 7,
  parameter int unsigned           RD_TIMEOUT = 16,
  parameter logic [STAT_ID_W-1:0]  STATUS_ID  = DEF_STATUS_ID,
  parameter logic [BYTE_W-1:0]     DUMMY_BYTE = DEF_DUMMY_BYTE
`ifdef SPI_REG_CTRL_ADDR_LIMIT_EN
  ,parameter int unsigned          MAX_ADDR   = 'h7F
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Trans_Start,
  input  logic                  Trans_End,
  input  logic                  Rx_Valid,
  input  logic [BYTE_W-1:0]     Rx_Data,
  output logic                  Tx_Load,
  output logic [BYTE_W-1:0]     Tx_Data,
  output logic                  Reg_Wr_En,
  output logic                  Reg_Rd_En,
  output logic [ADDR_W-1:0]     Reg_Addr,
  output logic [BYTE_W-1:0]     Reg_Wr_Data,
  input  logic [BYTE_W-1:0]     Reg_Rd_Data,
  input  logic                  Reg_Rd_Valid,
  output logic                  Busy,
  output logic                  Err_Rd_Timeout,
  output logic [BYTE_CNT_W-1:0] Byte_Cnt
`ifdef SPI_REG_CTRL_ADDR_LIMIT_EN
  ,output logic                 Err_Wr_Range
`endif
);

  state_e                  state_q, state_d;
  logic                    tx_load_q, tx_load_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    wr_en_q, wr_en_d;
  logic [BYTE_W-1:0]       wr_data_q, wr_data_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    err_rd_q, err_rd_d;
  logic                    wr_step_q, wr_step_d;
  logic                    err_wr_q, err_wr_d;

  logic                    tmr_start;
  logic                    tmr_run;
  logic                    tmr_expire;
  logic                    in_range;
  logic [BYTE_W-1:0]       status;

  assign tmr_run = (state_q == RD_WAIT);

  spi_reg_rd_timer #(
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start_i  (tmr_start),
    .run_i    (tmr_run),
    .hit_i    (Reg_Rd_Valid),
    .expire_c (tmr_expire)
  );

`ifdef SPI_REG_CTRL_ADDR_LIMIT_EN
  assign in_range = (32'(addr_q) <= MAX_ADDR);
  assign status   = status_byte(STATUS_ID, err_wr_q, err_rd_q);
`else
  assign in_range = 1'b1;
  assign status   = status_byte(STATUS_ID, 1'b0, err_rd_q);
`endif

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      err_rd_q  <= 1'b0;
      wr_step_q <= 1'b0;
      err_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      err_rd_q  <= err_rd_d;
      wr_step_q <= wr_step_d;
      err_wr_q  <= err_wr_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    tx_load_d = 1'b0;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_rd_d  = err_rd_q;
    wr_step_d = 1'b0;
    err_wr_d  = err_wr_q;
    tmr_start = 1'b0;

    // Address/count advance one cycle after a write byte was issued, so the
    // strobe cycle still presents the address being written.
    if (wr_step_q) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = sat_inc(cnt_q);
    end

    unique case (state_q)
      IDLE: ;
      CMD: begin
        if (Rx_Valid) begin
          addr_d = Rx_Data[ADDR_W-1:0];
          cnt_d  = '0;
          if (Rx_Data[CMD_RW_BIT]) begin
            state_d = RD_REQ;
            rd_en_d = 1'b1;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (Rx_Valid) begin
          wr_step_d = 1'b1;
          wr_data_d = Rx_Data;
          wr_en_d   = in_range;
          if (!in_range) err_wr_d = 1'b1;
          // Any write to address 0 clears the sticky error flags.
          if (in_range && addr_q == '0) begin
            err_rd_d = 1'b0;
            err_wr_d = 1'b0;
          end
        end
      end
      RD_REQ: begin
        state_d   = RD_WAIT;
        tmr_start = 1'b1;
      end
      RD_WAIT: begin
        if (Reg_Rd_Valid) begin
          tx_data_d = Reg_Rd_Data;
          tx_load_d = 1'b1;
          state_d   = RD_DATA;
        end else if (tmr_expire) begin
          tx_data_d = DUMMY_BYTE;
          tx_load_d = 1'b1;
          err_rd_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        // The byte clocked in during a read is don't-care; it only paces the prefetch.
        if (Rx_Valid) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = sat_inc(cnt_q);
          state_d = RD_REQ;
          rd_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chip-select release drops any outstanding read; a byte received in the
    // same cycle has already been processed above.
    if (Trans_End && state_q != IDLE) begin
      state_d = IDLE;
      rd_en_d = 1'b0;
      if (state_q == RD_WAIT) begin
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        err_rd_d  = err_rd_q;
      end
    end

    // Chip-select assert (also mid-transaction) restarts with the status byte.
    if (Trans_Start) begin
      state_d   = CMD;
      tx_load_d = 1'b1;
      tx_data_d = status;
      rd_en_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign Tx_Load        = tx_load_q;
  assign Tx_Data        = tx_data_q;
  assign Reg_Wr_En      = wr_en_q;
  assign Reg_Wr_Data    = wr_data_q;
  assign Reg_Rd_En      = rd_en_q;
  assign Reg_Addr       = addr_q;
  assign Busy           = busy_q;
  assign Err_Rd_Timeout = err_rd_q;
  assign Byte_Cnt       = cnt_q;
`ifdef SPI_REG_CTRL_ADDR_LIMIT_EN
  assign Err_Wr_Range   = err_wr_q;
`endif

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench for spi_slave_reg_ctrl: directed scenarios followed by
// random bursts, checked against a transaction-level reference model.
module tb_spi_slave_reg_ctrl;

  localparam int GAP = 30;

  logic        Clk;
  logic        Rst_n;
  logic        Trans_Start;
  logic        Trans_End;
  logic        Rx_Valid;
  logic [7:0]  Rx_Data;
  logic        Tx_Load;
  logic [7:0]  Tx_Data;
  logic        Reg_Wr_En;
  logic        Reg_Rd_En;
  logic [6:0]  Reg_Addr;
  logic [7:0]  Reg_Wr_Data;
  logic [7:0]  Reg_Rd_Data;
  logic        Reg_Rd_Valid;
  logic        Busy;
  logic        Err_Rd_Timeout;
  logic [15:0] Byte_Cnt;

  spi_slave_reg_ctrl dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .Trans_Start    (Trans_Start),
    .Trans_End      (Trans_End),
    .Rx_Valid       (Rx_Valid),
    .Rx_Data        (Rx_Data),
    .Tx_Load        (Tx_Load),
    .Tx_Data        (Tx_Data),
    .Reg_Wr_En      (Reg_Wr_En),
    .Reg_Rd_En      (Reg_Rd_En),
    .Reg_Addr       (Reg_Addr),
    .Reg_Wr_Data    (Reg_Wr_Data),
    .Reg_Rd_Data    (Reg_Rd_Data),
    .Reg_Rd_Valid   (Reg_Rd_Valid),
    .Busy           (Busy),
    .Err_Rd_Timeout (Err_Rd_Timeout),
    .Byte_Cnt       (Byte_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rd_tbl [128];
  logic [14:0] wr_log [$];
  logic [7:0]  tx_log [$];
  logic [6:0]  rd_log [$];
  logic [7:0]  wdat   [$];
  int          rsp_lat = 2;
  bit          rsp_mute = 1'b0;
  bit          m_err = 1'b0;

  // Monitor: record every bus event observed by the register file / SPI slave.
  always @(negedge Clk) begin
    if (Reg_Wr_En === 1'b1) wr_log.push_back({Reg_Addr, Reg_Wr_Data});
    if (Tx_Load   === 1'b1) tx_log.push_back(Tx_Data);
    if (Reg_Rd_En === 1'b1) rd_log.push_back(Reg_Addr);
  end

  // Register-file responder: returns rd_tbl[addr] rsp_lat cycles after the request.
  initial begin : responder
    logic [6:0] ra;
    int         lat;
    Reg_Rd_Valid = 1'b0;
    Reg_Rd_Data  = 8'h00;
    forever begin
      @(negedge Clk);
      if (Reg_Rd_En === 1'b1 && !rsp_mute) begin
        ra  = Reg_Addr;
        lat = rsp_lat;
        repeat (lat) @(negedge Clk);
        Reg_Rd_Data  = rd_tbl[ra];
        Reg_Rd_Valid = 1'b1;
        @(negedge Clk);
        Reg_Rd_Valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    Trans_Start = 1'b1;
    @(negedge Clk);
    Trans_Start = 1'b0;
  endtask

  task automatic pulse_end();
    Trans_End = 1'b1;
    @(negedge Clk);
    Trans_End = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    @(negedge Clk);
    Rx_Valid = 1'b0;
  endtask

  // One complete burst: model predicts writes, reads and transmitted bytes.
  task automatic run_txn(input bit is_rd, input logic [6:0] a, input int n, input int lat);
    int          wb, tb0, rb;
    logic [14:0] ew [$];
    logic [7:0]  et [$];
    logic [6:0]  er [$];
    logic [7:0]  b;
    logic [6:0]  ea;
    logic [31:0] obs;
    wb  = wr_log.size();
    tb0 = tx_log.size();
    rb  = rd_log.size();
    rsp_lat  = lat;
    rsp_mute = 1'b0;
    et.push_back({4'hA, 3'b000, m_err});
    if (is_rd) begin
      for (int i = 0; i <= n; i++) begin
        ea = a + 7'(i);
        er.push_back(ea);
        if (lat > 16) begin
          et.push_back(8'hEE);
          m_err = 1'b1;
        end else begin
          et.push_back(rd_tbl[ea]);
        end
      end
    end
    pulse_start();
    idle(4);
    rx({is_rd, a});
    idle(GAP);
    for (int i = 0; i < n; i++) begin
      if (is_rd) begin
        b = 8'($urandom);
      end else begin
        b  = (wdat.size() > 0) ? wdat.pop_front() : 8'($urandom);
        ea = a + 7'(i);
        ew.push_back({ea, b});
        if (ea == 7'h00) m_err = 1'b0;
      end
      rx(b);
      idle(GAP);
    end
    pulse_end();
    idle(3);
    chk("wr_count", 32'(wr_log.size() - wb), 32'(ew.size()));
    foreach (ew[i]) begin
      obs = (wb + i < wr_log.size()) ? 32'(wr_log[wb + i]) : 32'hDEAD_BEEF;
      chk("wr_addr_data", obs, 32'(ew[i]));
    end
    chk("tx_count", 32'(tx_log.size() - tb0), 32'(et.size()));
    foreach (et[i]) begin
      obs = (tb0 + i < tx_log.size()) ? 32'(tx_log[tb0 + i]) : 32'hDEAD_BEEF;
      chk("tx_data", obs, 32'(et[i]));
    end
    chk("rd_count", 32'(rd_log.size() - rb), 32'(er.size()));
    foreach (er[i]) begin
      obs = (rb + i < rd_log.size()) ? 32'(rd_log[rb + i]) : 32'hDEAD_BEEF;
      chk("rd_addr", obs, 32'(er[i]));
    end
    chk("busy_after_end", 32'(Busy), 32'd0);
    chk("byte_cnt", 32'(Byte_Cnt), 32'(n));
    ea = a + 7'(n);
    chk("addr_after", 32'(Reg_Addr), 32'(ea));
    chk("err_rd_timeout", 32'(Err_Rd_Timeout), 32'(m_err));
  endtask

  initial begin : stim
    int tb0, rb;
    Rst_n       = 1'b0;
    Trans_Start = 1'b0;
    Trans_End   = 1'b0;
    Rx_Valid    = 1'b0;
    Rx_Data     = 8'h00;
    for (int i = 0; i < 128; i++) rd_tbl[i] = 8'($urandom);
    rd_tbl[3] = 8'h5A;
    idle(3);

    // Reset values
    chk("rst_tx_load", 32'(Tx_Load), 32'd0);
    chk("rst_tx_data", 32'(Tx_Data), 32'd0);
    chk("rst_wr_en",   32'(Reg_Wr_En), 32'd0);
    chk("rst_rd_en",   32'(Reg_Rd_En), 32'd0);
    chk("rst_addr",    32'(Reg_Addr), 32'd0);
    chk("rst_wr_data", 32'(Reg_Wr_Data), 32'd0);
    chk("rst_busy",    32'(Busy), 32'd0);
    chk("rst_err",     32'(Err_Rd_Timeout), 32'd0);
    chk("rst_cnt",     32'(Byte_Cnt), 32'd0);
    Rst_n = 1'b1;
    idle(2);

    // Rx in IDLE is ignored
    rx(8'h12);
    idle(2);
    chk("idle_rx_busy", 32'(Busy), 32'd0);
    chk("idle_rx_addr", 32'(Reg_Addr), 32'd0);

    // Write burst 0x05: 0x11, 0x22 (status 0xA0)
    wdat = '{8'h11, 8'h22};
    run_txn(1'b0, 7'h05, 2, 0);

    // Read burst at 0x03, latency 2
    run_txn(1'b1, 7'h03, 1, 2);

    // Read timeout at 0x10
    run_txn(1'b1, 7'h10, 0, 20);

    // Status now reports the timeout; write elsewhere keeps it set
    run_txn(1'b0, 7'h20, 1, 0);

    // Write to address 0 clears the flag in the Reg_Wr_En cycle
    pulse_start();
    idle(4);
    rx(8'h00);
    idle(GAP);
    chk("err_before_clr", 32'(Err_Rd_Timeout), 32'd1);
    rx(8'h00);
    chk("clr_wr_en", 32'(Reg_Wr_En), 32'd1);
    chk("clr_addr",  32'(Reg_Addr), 32'd0);
    chk("clr_err",   32'(Err_Rd_Timeout), 32'd0);
    idle(GAP);
    pulse_end();
    idle(3);
    m_err = 1'b0;

    // Latency boundary: 16 is still accepted, 17 times out
    run_txn(1'b1, 7'h40, 1, 16);
    run_txn(1'b1, 7'h41, 0, 17);

    // Address wrap 0x7F -> 0x00 (write to 0 also clears the flag)
    wdat = '{8'h01, 8'h02};
    run_txn(1'b0, 7'h7F, 2, 0);

    // Abort during RD_WAIT, late read data must be ignored
    tb0 = tx_log.size();
    rb  = rd_log.size();
    rsp_lat = 10;
    pulse_start();
    idle(4);
    rx(8'h85);
    idle(4);
    pulse_end();
    idle(20);
    chk("abort_tx_count", 32'(tx_log.size() - tb0), 32'd1);
    chk("abort_rd_count", 32'(rd_log.size() - rb), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);

    // Rx_Valid and Trans_End together in WR_DATA
    pulse_start();
    idle(4);
    rx(8'h0A);
    idle(GAP);
    Rx_Data   = 8'h33;
    Rx_Valid  = 1'b1;
    Trans_End = 1'b1;
    @(negedge Clk);
    Rx_Valid  = 1'b0;
    Trans_End = 1'b0;
    chk("sim_wr_en",   32'(Reg_Wr_En), 32'd1);
    chk("sim_wr_data", 32'(Reg_Wr_Data), 32'h33);
    chk("sim_addr",    32'(Reg_Addr), 32'h0A);
    chk("sim_busy",    32'(Busy), 32'd0);
    idle(3);
    chk("sim_cnt",     32'(Byte_Cnt), 32'd1);
    chk("sim_addr_inc", 32'(Reg_Addr), 32'h0B);

    // Random bursts
    for (int k = 0; k < 14; k++) begin
      run_txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
              int'($urandom_range(1, 3)), int'($urandom_range(1, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
